// File: rtl/brentkung_pkg.sv
// Shared Brent-Kung definitions: datapath width and the generate/propagate prefix operator.
package brentkung_pkg;

    localparam int unsigned BK_WIDTH = 16;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // (g, p) o (g', p') = (g | p & g', p & p'); hi is the more significant span
    function automatic gp_t bk_op(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/brentkung_prefix16.sv
// Combinational 16-bit Brent-Kung carry network: 4 up-sweep levels, 3 down-sweep levels.
module brentkung_prefix16
    import brentkung_pkg::*;
(
    input  logic [BK_WIDTH-1:0] g,
    input  logic [BK_WIDTH-1:0] p,
    input  logic                cin,
    output logic [BK_WIDTH:0]   c
);

    gp_t node [BK_WIDTH];

    always_comb begin
        for (int i = 0; i < int'(BK_WIDTH); i++) begin
            node[4'(i)].g = g[4'(i)];
            node[4'(i)].p = p[4'(i)];
        end
        // Fold carry-in into bit 0 so every prefix already includes it
        node[0].g = g[0] | (p[0] & cin);

        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < int'(BK_WIDTH); i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    node[4'(i)] = bk_op(node[4'(i)], node[4'(i - (1 << l))]);
                end
            end
        end

        for (int l = 2; l >= 0; l--) begin
            for (int i = 0; i < int'(BK_WIDTH); i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (3 * (1 << l)) - 1)) begin
                    node[4'(i)] = bk_op(node[4'(i)], node[4'(i - (1 << l))]);
                end
            end
        end

        c[0] = cin;
        for (int i = 0; i < int'(BK_WIDTH); i++) begin
            c[5'(i + 1)] = node[4'(i)].g;
        end
    end

endmodule

// File: rtl/brentkung_subtractor_pipe.sv
// Two-stage pipelined X - Y - Bin using the Brent-Kung prefix network, valid/ready on both sides.
module brentkung_subtractor_pipe
    import brentkung_pkg::*;
#(
    parameter int unsigned WIDTH = BK_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bin,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] DIFF,
    output logic             Bout,
    output logic             OVF,
    output logic             ZERO
);

    logic             valid_a_q, valid_a_d;
    logic [WIDTH-1:0] x_a_q, x_a_d;
    logic [WIDTH-1:0] yn_a_q, yn_a_d;
    logic [WIDTH-1:0] g_a_q, g_a_d;
    logic [WIDTH-1:0] p_a_q, p_a_d;
    logic             cin_a_q, cin_a_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             load_b_c;
    logic             load_a_c;
    logic             accept_c;
    logic [WIDTH:0]   carry_c;
    logic [WIDTH-1:0] diff_c;

    brentkung_prefix16 u_prefix (
        .g   (g_a_q),
        .p   (p_a_q),
        .cin (cin_a_q),
        .c   (carry_c)
    );

    always_comb begin
        load_b_c = !out_valid_q || OUT_READY;
        load_a_c = !valid_a_q || load_b_c;
        accept_c = IN_VALID && load_a_c;
        diff_c   = x_a_q ^ yn_a_q ^ carry_c[WIDTH-1:0];

        valid_a_d   = valid_a_q;
        x_a_d       = x_a_q;
        yn_a_d      = yn_a_q;
        g_a_d       = g_a_q;
        p_a_d       = p_a_q;
        cin_a_d     = cin_a_q;
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;

        // Stage A: capture operands as X + ~Y + ~Bin
        if (load_a_c) begin
            valid_a_d = accept_c;
            if (accept_c) begin
                x_a_d   = X;
                yn_a_d  = ~Y;
                g_a_d   = X & ~Y;
                p_a_d   = X ^ ~Y;
                cin_a_d = ~Bin;
            end
        end

        // Stage B: resolve carries and flags; an empty stage A leaves a bubble
        if (load_b_c) begin
            out_valid_d = valid_a_q;
            if (valid_a_q) begin
                diff_d = diff_c;
                bout_d = ~carry_c[WIDTH];
                ovf_d  = (x_a_q[WIDTH-1] ^ ~yn_a_q[WIDTH-1]) & (diff_c[WIDTH-1] ^ x_a_q[WIDTH-1]);
                zero_d = (diff_c == '0);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_a_q   <= 1'b0;
            x_a_q       <= '0;
            yn_a_q      <= '0;
            g_a_q       <= '0;
            p_a_q       <= '0;
            cin_a_q     <= 1'b0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            valid_a_q   <= valid_a_d;
            x_a_q       <= x_a_d;
            yn_a_q      <= yn_a_d;
            g_a_q       <= g_a_d;
            p_a_q       <= p_a_d;
            cin_a_q     <= cin_a_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign IN_READY  = load_a_c;
    assign OUT_VALID = out_valid_q;
    assign DIFF      = diff_q;
    assign Bout      = bout_q;
    assign OVF       = ovf_q;
    assign ZERO      = zero_q;

endmodule

// File: tb/tb_brentkung_subtractor_pipe.sv
// Scoreboard bench for brentkung_subtractor_pipe: directed vectors, backpressure, reset, random.
module tb_brentkung_subtractor_pipe;

    typedef struct {
        logic [15:0] d;
        logic        b;
        logic        o;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    int   rdy_mode = 0;
    int   pat_cnt  = 0;
    exp_t sb[$];
    logic        held_v = 1'b0;
    logic [18:0] held;

    brentkung_subtractor_pipe dut (
        .CLK       (clk),
        .RST       (rst),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .X         (x),
        .Y         (y),
        .Bin       (bin),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .DIFF      (diff),
        .Bout      (bout),
        .OVF       (ovf),
        .ZERO      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] d, input logic b, input logic o, input logic z);
        exp_t e;
        e.d = d; e.b = b; e.o = o; e.z = z;
        return e;
    endfunction

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] s, input logic bi);
        exp_t e;
        int ud;
        int sd;
        ud  = int'(a) - int'(s) - int'(bi);
        sd  = int'($signed(a)) - int'($signed(s)) - int'(bi);
        e.d = 16'(ud);
        e.b = (ud < 0);
        e.o = (sd > 32767) || (sd < -32768);
        e.z = (e.d == 16'h0);
        return e;
    endfunction

    // Ready pattern driver: 0 always, 1 one-on/two-off, 2 random, 3 stalled
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((pat_cnt % 3) == 0);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        pat_cnt++;
    end

    // Monitor: sampled mid-cycle, acts on the handshake that completes at the next rising edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", in_ready, !((sb.size() == 2) && !out_ready));
            if (held_v) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", {diff, bout, ovf, zero}, held);
            end
            held_v = out_valid && !out_ready;
            held   = {diff, bout, ovf, zero};
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got diff %0h, expected no result", diff);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("diff", diff, e.d);
                    chk("bout", bout, e.b);
                    chk("ovf",  ovf,  e.o);
                    chk("zero", zero, e.z);
                    n_out++;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge with IN_VALID still high
    task automatic send(input logic [15:0] a, input logic [15:0] s, input logic bi, input exp_t e);
        bit done = 0;
        in_valid = 1'b1;
        x = a; y = s; bin = bi;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                sb.push_back(e);
                done = 1;
            end else begin
                @(posedge clk);
            end
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no IN_READY, expected accept within 1000 cycles");
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        x   = 16'($urandom);
        y   = 16'($urandom);
        bin = 1'($urandom);
    endtask

    task automatic drain(input int budget);
        for (int t = 0; t < budget && sb.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int base;
        logic [15:0] ra, rs;
        logic        rb;
        rst = 1'b1;
        in_valid = 1'b0; x = '0; y = '0; bin = 1'b0;
        out_ready = 1'b1;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_outputs",   {diff, bout, ovf, zero}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Latency and basic result
        send(16'd87, 16'd20, 1'b1, mk(16'd66, 0, 0, 0));
        idle();
        @(negedge clk);
        chk("latency_edge1", out_valid, 0);
        @(negedge clk);
        chk("latency_edge2", out_valid, 1);
        drain(20);

        // Borrow and flag vectors
        send(16'd20,    16'd87,   1'b0, mk(16'hFFBD, 1, 0, 0));
        send(16'd0,     16'd0,    1'b1, mk(16'hFFFF, 1, 0, 0));
        send(16'h8000,  16'd1,    1'b0, mk(16'h7FFF, 0, 1, 0));
        send(16'd5000,  16'd5000, 1'b0, mk(16'h0000, 0, 0, 1));
        idle();
        drain(20);

        // Backpressure stream
        rdy_mode = 1;
        send(16'd25000, 16'd4801, 1'b0, mk(16'd20199, 0, 0, 0));
        send(16'd3150,  16'd5800, 1'b0, mk(16'd62886, 1, 0, 0));
        send(16'd100,   16'd100,  1'b1, mk(16'hFFFF,  1, 0, 0));
        send(16'h7FFF,  16'hFFFF, 1'b0, mk(16'h8000,  1, 1, 0));
        send(16'd1234,  16'd234,  1'b0, mk(16'd1000,  0, 0, 0));
        send(16'h8000,  16'h8000, 1'b1, mk(16'hFFFF,  1, 0, 0));
        idle();
        drain(100);

        // Asynchronous reset with two results in flight
        rdy_mode = 3;
        @(posedge clk); #1;
        send(16'd10, 16'd3, 1'b0, mk(16'd7, 0, 0, 0));
        send(16'd9,  16'd9, 1'b0, mk(16'd0, 0, 0, 1));
        idle();
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_outputs",   {diff, bout, ovf, zero}, 0);
        chk("midrst_in_ready",  in_ready, 1);
        sb.delete();
        held_v = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        base = n_out;
        @(posedge clk); #1;
        send(16'd300, 16'd1, 1'b1, mk(16'd298, 0, 0, 0));
        idle();
        drain(20);
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_count", n_out - base, 1);

        // Random regression
        rdy_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rs = 16'($urandom);
            rb = 1'($urandom);
            if ((i % 8) == 0) rs = ra;
            send(ra, rs, rb, model(ra, rs, rb));
            if ((i % 5) == 0) begin
                idle();
                @(posedge clk); #1;
            end
        end
        idle();
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
